mesm6_acc_ctl: RTL and testbench
================================

# mesm6_acc_ctl

Accumulator/Y register stage wrapped around `mesm6_alu`. It accepts one arithmetic request at a time from the control unit and drives the ALU operands and opcode. It waits for `done`, writes `result` and `y` back into the accumulator (A) and Y register, then returns the ALU to `ALU_NOP` so the next operation starts cleanly. It also sequences the two-uop ACX instruction (`ALU_COUNT` then `ALU_ADD_CARRY_AROUND`) and provides a direct load path for XTA-style accumulator writes.

## Interface
- `ACC_INIT`, default 48'h0: reset value of A and Y.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request strobe from control unit.
- `req_ready` out 1: high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_op` in `ALU_OP_WIDTH`: ALU opcode; ignored when `req_acx`=1.
- `req_operand` in 48: operand B (memory word / shift count).
- `req_acx` in 1: run the ACX sequence instead of `req_op`.
- `load_valid` in 1: direct write A<=`load_data`, Y unchanged; honoured only in IDLE, and wins over `req_valid` in the same cycle.
- `load_data` in 48: direct load value.
- `acc` out 48: accumulator A.
- `yreg` out 48: Y register.
- `resp_valid` out 1: one-cycle pulse, coincident with the final A/Y writeback.
- `omega` out 1: condition flag (see Configuration).
- `alu_a` out 48, `alu_b` out 48, `alu_op` out `ALU_OP_WIDTH`: registered ALU inputs.
- `alu_result` in 48, `alu_y` in 48, `alu_done` in 1: ALU outputs.

## Operation
- States: IDLE, WAIT, DRAIN.
- **IDLE**
  - `alu_op`=`ALU_NOP`.
  - On accept: latch operand into `alu_b`, set `alu_a`<=A.
  - Set `alu_op`<=`req_op`, or `ALU_COUNT` if `req_acx`; latch an internal `acx_pend`<=`req_acx`.
  - Go to WAIT.
- **WAIT**
  - Hold `alu_a`/`alu_b`/`alu_op` stable.
  - On `alu_done`=1:
    - If `acx_pend`: capture `alu_result` into `alu_a` only; A/Y are not written.
    - Otherwise: A<=`alu_result`, Y<=`alu_y`, pulse `resp_valid`.
  - In both cases set `alu_op`<=`ALU_NOP` and go to DRAIN.
- **DRAIN**
  - `alu_done` is ignored here, because the ALU clears `done` on this edge.
  - If `acx_pend`: `alu_op`<=`ALU_ADD_CARRY_AROUND`, `acx_pend`<=0, go to WAIT. `alu_b` still holds the original operand, so the result is popcount(A)+operand with end-around carry.
  - Otherwise go to IDLE.
- Unimplemented opcodes never assert `done`, so the block stays in WAIT. There is no timeout; the control unit must not issue them.
- `alu_op`=`ALU_NOP` is never issued as a request. `req_op`=`ALU_NOP` with `req_acx`=0 is illegal.

## Timing
- Edge numbering: T = accept edge.
- 1-cycle ALU ops (AND/OR/XOR/SHIFT/COUNT):
  - ALU `done` at T+1.
  - A/Y written and `resp_valid` at T+2.
  - DRAIN at T+3; `req_ready` high after T+3.
- ARX (2 ALU cycles): writeback at T+3, IDLE after T+4.
- ACX:
  - COUNT captured at T+2.
  - DRAIN at T+3 issues ARX.
  - ARX `done` at T+5, writeback at T+6, IDLE after T+7.
- `load_valid` in IDLE: A updated on the same edge, no `resp_valid`, state unchanged.
- Reset (any state, including mid-ACX):
  - A=Y=`ACC_INIT`.
  - `alu_op`=`ALU_NOP`, `alu_a`=`alu_b`=0.
  - `acx_pend`=0, `resp_valid`=0, `omega`=0, state IDLE.
  - The ALU sees NOP on the next cycle and clears its `done`.
- `req_ready` is combinational from state (IDLE and not `load_valid`) and is low during reset.

## Configuration
- `MESM6_ACC_OMEGA_EN` defined:
  - On every final writeback (not the intermediate COUNT capture), `omega`<=(`alu_result`==0).
  - On `load_valid`, `omega`<=(`load_data`==0).
  - The value holds otherwise.
- Not defined: `omega` is constant 0 and no flag logic is generated.

## Test plan
- A=48'hFF00FF00FF00 by load; request `ALU_AND`, operand 48'h0F0F0F0F0F0F -> A=48'h0F000F000F00, Y=0, `resp_valid` at T+2, `req_ready` returns after T+3.
- A=48'hFFFFFFFFFFFF; `ALU_ADD_CARRY_AROUND`, operand 1 -> A=48'h000000000001 at T+3. With the macro, `omega`=0. With operand 0 and A=0: A=0, and `omega`=1 when the macro is defined.
- A=48'h000000000007; `req_acx`, operand 48'h10 -> intermediate `alu_a`=3, final A=48'h13 at T+6, a single `resp_valid` pulse.
- `ALU_XOR`, A=48'h5, operand 48'h3 -> A=48'h6, Y=48'h5. `alu_op` is NOP at the DRAIN edge, and a stale `done` does not cause a second writeback.
- Assert `reset` during ACX WAIT (second uop) -> next cycle A=Y=`ACC_INIT`, `alu_op`=NOP, IDLE; a following AND completes normally.
- `load_valid` and `req_valid` together in IDLE -> load wins, the request is not accepted (`req_ready`=0), and it is accepted the next cycle.

Source files
------------

// File: rtl/mesm6_acc_ctl.sv
// Accumulator (A) / Y register stage that sequences mesm6_alu requests, including the two-uop ACX.
// Optional zero flag on final writeback / direct load is enabled by defining MESM6_ACC_OMEGA_EN.
module mesm6_acc_ctl #(
    parameter logic [47:0]             ACC_INIT             = 48'h0,
    parameter int                      ALU_OP_WIDTH         = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_NOP              = 'd0,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_COUNT            = 'd5,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD_CARRY_AROUND = 'd6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ALU_OP_WIDTH-1:0] req_op,
    input  logic [47:0]             req_operand,
    input  logic                    req_acx,
    input  logic                    load_valid,
    input  logic [47:0]             load_data,
    output logic [47:0]             acc,
    output logic [47:0]             yreg,
    output logic                    resp_valid,
    output logic                    omega,
    output logic [47:0]             alu_a,
    output logic [47:0]             alu_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [47:0]             alu_result,
    input  logic [47:0]             alu_y,
    input  logic                    alu_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [47:0]             r_acc;
    logic [47:0]             r_y;
    logic [47:0]             r_alu_a;
    logic [47:0]             r_alu_b;
    logic [ALU_OP_WIDTH-1:0] r_alu_op;
    logic                    r_acx_pend;
    logic                    r_resp_valid;
    logic                    w_load;
    logic                    w_accept;
    logic                    w_final_wb;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; alu_done is deliberately not looked at in DRAIN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_WAIT;
            S_WAIT:  if (alu_done) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = r_acx_pend ? S_WAIT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output / handshake logic
    always_comb begin
        req_ready  = (r_state == S_IDLE) && !load_valid && !reset;
        w_load     = (r_state == S_IDLE) && load_valid;
        w_accept   = req_valid && req_ready;
        w_final_wb = (r_state == S_WAIT) && alu_done && !r_acx_pend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= ACC_INIT;
            r_y          <= ACC_INIT;
            r_alu_a      <= 48'h0;
            r_alu_b      <= 48'h0;
            r_alu_op     <= ALU_NOP;
            r_acx_pend   <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_acc <= load_data;
                    end else if (w_accept) begin
                        r_alu_a    <= r_acc;
                        r_alu_b    <= req_operand;
                        r_alu_op   <= req_acx ? ALU_COUNT : req_op;
                        r_acx_pend <= req_acx;
                    end
                end
                S_WAIT: begin
                    if (alu_done) begin
                        r_alu_op <= ALU_NOP;
                        if (r_acx_pend) begin
                            // popcount becomes the first operand of the carry-around add
                            r_alu_a <= alu_result;
                        end else begin
                            r_acc        <= alu_result;
                            r_y          <= alu_y;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_acx_pend) begin
                        r_alu_op   <= ALU_ADD_CARRY_AROUND;
                        r_acx_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MESM6_ACC_OMEGA_EN
    logic r_omega;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_omega <= 1'b0;
        end else if (w_load) begin
            r_omega <= (load_data == 48'h0);
        end else if (w_final_wb) begin
            r_omega <= (alu_result == 48'h0);
        end
    end

    assign omega = r_omega;
`else
    assign omega = 1'b0;
`endif

    assign acc        = r_acc;
    assign yreg       = r_y;
    assign resp_valid = r_resp_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;

endmodule

// File: tb/tb_mesm6_acc_ctl.sv
// Bench for mesm6_acc_ctl: ALU stub, transaction-level model, per-cycle compare and directed vectors.
module tb_mesm6_acc_ctl;

    localparam logic [3:0]  OP_NOP   = 4'd0;
    localparam logic [3:0]  OP_AND   = 4'd1;
    localparam logic [3:0]  OP_OR    = 4'd2;
    localparam logic [3:0]  OP_XOR   = 4'd3;
    localparam logic [3:0]  OP_COUNT = 4'd5;
    localparam logic [3:0]  OP_ARX   = 4'd6;
    localparam logic [47:0] INIT     = 48'h123456789ABC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = OP_NOP;
    logic [47:0] req_operand = 48'h0;
    logic        req_acx = 1'b0;
    logic        load_valid = 1'b0;
    logic [47:0] load_data = 48'h0;
    logic [47:0] acc, yreg, alu_a, alu_b;
    logic        resp_valid, omega;
    logic [3:0]  alu_op;
    logic [47:0] alu_result = 48'h0;
    logic [47:0] alu_y = 48'h0;
    logic        alu_done = 1'b0;
    int          alu_cnt = 0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    mesm6_acc_ctl #(
        .ACC_INIT(INIT), .ALU_OP_WIDTH(4), .ALU_NOP(OP_NOP),
        .ALU_COUNT(OP_COUNT), .ALU_ADD_CARRY_AROUND(OP_ARX)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_operand(req_operand), .req_acx(req_acx),
        .load_valid(load_valid), .load_data(load_data),
        .acc(acc), .yreg(yreg), .resp_valid(resp_valid), .omega(omega),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_y(alu_y), .alu_done(alu_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour: returns {result, y}
    function automatic logic [95:0] alu_f(input logic [3:0] op, input logic [47:0] a, input logic [47:0] b);
        logic [48:0] s;
        case (op)
            OP_AND:   return {a & b, 48'h0};
            OP_OR:    return {a | b, 48'h0};
            OP_XOR:   return {a ^ b, a};
            OP_COUNT: return {48'($countones(a)), 48'h0};
            OP_ARX: begin
                s = {1'b0, a} + {1'b0, b};
                return {s[47:0] + {47'h0, s[48]}, 48'h0};
            end
            default:  return 96'h0;
        endcase
    endfunction

    function automatic int alu_lat(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_COUNT: return 1;
            OP_ARX:                          return 2;
            default:                         return 0;
        endcase
    endfunction

    // ALU stub: done stays high until it sees NOP, then drops on the following edge
    always @(posedge clk) begin
        if (alu_op == OP_NOP) begin
            alu_done <= 1'b0;
            alu_cnt  <= 0;
        end else if (!alu_done) begin
            if (alu_cnt + 1 == alu_lat(alu_op)) begin
                alu_done <= 1'b1;
                {alu_result, alu_y} <= alu_f(alu_op, alu_a, alu_b);
            end
            alu_cnt <= alu_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model state
    logic [47:0] m_acc = 48'h0, m_y = 48'h0, wb_acc = 48'h0, wb_y = 48'h0, ld_val = 48'h0;
    logic        m_omega = 1'b0;
    logic        exp_resp, exp_ready;
    bit          chk_en = 0, wb_pend = 0, ld_pend = 0, rst_pend = 0;
    int          wb_cyc = 0, ld_cyc = 0, rst_cyc = 0, acc_cyc = 0, busy_end = 0;

    // Compare process: at negedge+2, after the driver's previous changes have settled
    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            exp_resp = 1'b0;
            if (rst_pend && cyc == rst_cyc) begin
                m_acc = INIT; m_y = INIT; m_omega = 1'b0;
                wb_pend = 0; busy_end = cyc; rst_pend = 0;
            end
            if (ld_pend && cyc == ld_cyc) begin
                m_acc = ld_val;
`ifdef MESM6_ACC_OMEGA_EN
                m_omega = (ld_val == 48'h0);
`endif
                ld_pend = 0;
            end
            if (wb_pend && cyc == wb_cyc) begin
                m_acc = wb_acc; m_y = wb_y; exp_resp = 1'b1;
`ifdef MESM6_ACC_OMEGA_EN
                m_omega = (wb_acc == 48'h0);
`endif
                wb_pend = 0;
            end
            exp_ready = !reset && !load_valid && !(cyc >= acc_cyc && cyc < busy_end);
            chk("acc", acc, m_acc);
            chk("yreg", yreg, m_y);
            chk("resp_valid", {47'h0, resp_valid}, {47'h0, exp_resp});
            chk("req_ready", {47'h0, req_ready}, {47'h0, exp_ready});
            chk("omega", {47'h0, omega}, {47'h0, m_omega});
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic do_load(input logic [47:0] d);
        load_valid = 1'b1; load_data = d;
        ld_val = d; ld_pend = 1; ld_cyc = cyc + 1;
        step();
        load_valid = 1'b0;
    endtask

    // Issues a request now; returns one cycle later with cyc == accept edge
    task automatic do_req(input logic [3:0] op, input logic [47:0] b, input logic acx);
        logic [95:0] r;
        int t;
        req_valid = 1'b1; req_op = op; req_operand = b; req_acx = acx;
        t = cyc + 1;
        acc_cyc = t;
        if (acx) begin
            r = alu_f(OP_COUNT, m_acc, b);
            r = alu_f(OP_ARX, r[95:48], b);
            wb_cyc = t + 6; busy_end = t + 7;
        end else begin
            r = alu_f(op, m_acc, b);
            wb_cyc = t + 1 + alu_lat(op); busy_end = t + 2 + alu_lat(op);
        end
        wb_acc = r[95:48]; wb_y = r[47:0]; wb_pend = 1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) step();
    endtask

    logic [95:0] pin;

    initial begin
        // Pin the model with hand-computed values
        pin = alu_f(OP_AND, 48'hFF00FF00FF00, 48'h0F0F0F0F0F0F);
        chk("model_and", pin[95:48], 48'h0F000F000F00);
        pin = alu_f(OP_ARX, 48'hFFFFFFFFFFFF, 48'h1);
        chk("model_arx", pin[95:48], 48'h000000000001);
        pin = alu_f(OP_XOR, 48'h5, 48'h3);
        chk("model_xor", pin, {48'h6, 48'h5});
        pin = alu_f(OP_COUNT, 48'h7, 48'h10);
        chk("model_count", pin[95:48], 48'h3);

        repeat (3) @(posedge clk);
        step();
        reset = 1'b0;
        m_acc = INIT; m_y = INIT; m_omega = 1'b0; chk_en = 1;
        step();
        chk("reset_acc", acc, INIT);
        chk("reset_alu_op", {44'h0, alu_op}, {44'h0, OP_NOP});
        chk("reset_alu_a", alu_a, 48'h0);

        // AND
        do_load(48'hFF00FF00FF00);
        do_req(OP_AND, 48'h0F0F0F0F0F0F, 1'b0);
        step(); step();
        chk("and_resp_t2", {47'h0, resp_valid}, 48'h1);
        wait_idle();
        chk("and_acc", acc, 48'h0F000F000F00);
        chk("and_y", yreg, 48'h0);

        // Carry-around add
        do_load(48'hFFFFFFFFFFFF);
        do_req(OP_ARX, 48'h1, 1'b0);
        wait_idle();
        chk("arx_acc", acc, 48'h1);
        do_load(48'h0);
        do_req(OP_ARX, 48'h0, 1'b0);
        wait_idle();
        chk("arx_zero_acc", acc, 48'h0);
`ifdef MESM6_ACC_OMEGA_EN
        chk("arx_zero_omega", {47'h0, omega}, 48'h1);
`endif

        // ACX
        do_load(48'h7);
        do_req(OP_NOP, 48'h10, 1'b1);
        step(); step();
        chk("acx_mid_alu_a", alu_a, 48'h3);
        chk("acx_mid_acc", acc, 48'h7);
        wait_idle();
        chk("acx_acc", acc, 48'h13);

        // XOR and stale-done handling
        do_load(48'h5);
        do_req(OP_XOR, 48'h3, 1'b0);
        step(); step();
        chk("xor_op_wb", {44'h0, alu_op}, {44'h0, OP_NOP});
        step();
        chk("xor_op_drain", {44'h0, alu_op}, {44'h0, OP_NOP});
        wait_idle();
        chk("xor_acc", acc, 48'h6);
        chk("xor_y", yreg, 48'h5);

        // OR
        do_req(OP_OR, 48'hA00000000000, 1'b0);
        wait_idle();
        chk("or_acc", acc, 48'hA00000000006);

        // Reset during the second ACX uop
        do_load(48'h7);
        do_req(OP_NOP, 48'h10, 1'b1);
        step(); step(); step();
        chk("acx2_op_arx", {44'h0, alu_op}, {44'h0, OP_ARX});
        reset = 1'b1; rst_pend = 1; rst_cyc = cyc + 1;
        step();
        reset = 1'b0;
        chk("rst_acc", acc, INIT);
        chk("rst_alu_op", {44'h0, alu_op}, {44'h0, OP_NOP});
        chk("rst_alu_b", alu_b, 48'h0);
        do_req(OP_AND, 48'h0000FFFF0000, 1'b0);
        wait_idle();
        chk("post_rst_and", acc, 48'h000056780000);

        // Load and request in the same cycle: load wins
        load_valid = 1'b1; load_data = 48'h00000000000F;
        ld_val = 48'hF; ld_pend = 1; ld_cyc = cyc + 1;
        req_valid = 1'b1; req_op = OP_AND; req_operand = 48'h3; req_acx = 1'b0;
        #1;
        chk("ready_with_load", {47'h0, req_ready}, 48'h0);
        step();
        load_valid = 1'b0;
        do_req(OP_AND, 48'h3, 1'b0);
        wait_idle();
        chk("load_then_and", acc, 48'h3);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
